// File: rtl/uart_word_loader_if.sv
// Byte-in / word-out bus between uart_rx and the program memory loader.
// Carries the optional checksum output when UART_LOADER_CHECKSUM_EN is defined.
interface uart_word_loader_if #(
  parameter int WORD_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);
  logic                  load_en;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic [WORD_WIDTH-1:0] word_data;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic                  word_write;
  logic [ADDR_WIDTH-1:0] word_count;
  logic                  wrapped;
  logic                  resync;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [WORD_WIDTH-1:0] checksum;
`endif

  // master: the loader, which drives the memory write side
  modport master (
    input  load_en, byte_data, byte_ready,
`ifdef UART_LOADER_CHECKSUM_EN
    output checksum,
`endif
    output word_data, word_addr, word_write, word_count, wrapped, resync
  );

  modport slave (
    output load_en, byte_data, byte_ready,
`ifdef UART_LOADER_CHECKSUM_EN
    input  checksum,
`endif
    input  word_data, word_addr, word_write, word_count, wrapped, resync
  );
endinterface

// File: rtl/uart_word_loader.sv
// Assembles little-endian UART byte pairs into memory words during load mode.
// Optional image checksum output enabled by defining UART_LOADER_CHECKSUM_EN.
module uart_word_loader #(
  parameter int WORD_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 16,
  parameter int MEM_LEN        = 65536,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic                clk_50M,
  input logic                rst,
  uart_word_loader_if.master bus
);
  // state   | meaning
  // IDLE    | load mode off; session counters/flags hold their values
  // WAIT_LO | waiting for the low byte of the next word
  // WAIT_HI | low byte held; waiting for high byte, timeout running
  // WRITE   | one-cycle write strobe for the assembled word
  typedef enum logic [1:0] {IDLE, WAIT_LO, WAIT_HI, WRITE} state_t;

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]         TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(MEM_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] COUNT_MAX  = '1;

  state_t                state, state_nxt;
  logic                  byte_ready_q;
  logic                  byte_ev;
  logic [7:0]            lo_byte;
  logic [TW-1:0]         timer;
  logic [WORD_WIDTH-1:0] word_data_r;
  logic [ADDR_WIDTH-1:0] word_addr_r;
  logic [ADDR_WIDTH-1:0] word_count_r;
  logic                  wrapped_r;
  logic                  resync_r;
  logic                  session_clr, lo_ld, word_ld, timeout, strobe;

  assign byte_ev = bus.byte_ready & ~byte_ready_q;

  always_ff @(posedge clk_50M) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Dropping load_en wins over everything, including a pending strobe
  always_comb begin
    state_nxt   = state;
    session_clr = 1'b0;
    lo_ld       = 1'b0;
    word_ld     = 1'b0;
    timeout     = 1'b0;
    strobe      = 1'b0;
    if (!bus.load_en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          session_clr = 1'b1;
          state_nxt   = WAIT_LO;
        end
        WAIT_LO: begin
          if (byte_ev) begin
            lo_ld     = 1'b1;
            state_nxt = WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (byte_ev) begin
            word_ld   = 1'b1;
            state_nxt = WRITE;
          end else if (timer == '0) begin
            timeout   = 1'b1;
            state_nxt = WAIT_LO;
          end
        end
        WRITE: begin
          strobe    = 1'b1;
          state_nxt = WAIT_LO;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      byte_ready_q <= 1'b0;
      lo_byte      <= '0;
      timer        <= '0;
      word_data_r  <= '0;
      word_addr_r  <= '0;
      word_count_r <= '0;
      wrapped_r    <= 1'b0;
      resync_r     <= 1'b0;
    end else begin
      byte_ready_q <= bus.byte_ready;
      if (session_clr) begin
        word_addr_r  <= '0;
        word_count_r <= '0;
        wrapped_r    <= 1'b0;
        resync_r     <= 1'b0;
      end
      if (lo_ld) begin
        lo_byte <= bus.byte_data;
        timer   <= TIMER_LOAD;
      end else if (state == WAIT_HI && timer != '0) begin
        timer <= timer - TW'(1);
      end
      if (word_ld) word_data_r <= {bus.byte_data, lo_byte};
      if (timeout) resync_r <= 1'b1;
      if (strobe) begin
        if (word_addr_r == ADDR_LAST) begin
          word_addr_r <= '0;
          wrapped_r   <= 1'b1;
        end else begin
          word_addr_r <= word_addr_r + ADDR_WIDTH'(1);
        end
        if (word_count_r != COUNT_MAX) word_count_r <= word_count_r + ADDR_WIDTH'(1);
      end
    end
  end

`ifdef UART_LOADER_CHECKSUM_EN
  logic [WORD_WIDTH-1:0] checksum_r;

  always_ff @(posedge clk_50M) begin
    if (rst)              checksum_r <= '0;
    else if (session_clr) checksum_r <= '0;
    else if (strobe)      checksum_r <= checksum_r + word_data_r;
  end

  assign bus.checksum = checksum_r;
`endif

  assign bus.word_data  = word_data_r;
  assign bus.word_addr  = word_addr_r;
  assign bus.word_write = strobe & ~rst;
  assign bus.word_count = word_count_r;
  assign bus.wrapped    = wrapped_r;
  assign bus.resync     = resync_r;

endmodule

// File: tb/tb_uart_word_loader.sv
// Directed and randomized bench for uart_word_loader against a byte-stream reference model.
// Checksum checks are included when UART_LOADER_CHECKSUM_EN is defined.
module tb_uart_word_loader;
  localparam int  WW  = 16;
  localparam int  AW  = 16;
  localparam int  ML  = 8;
  localparam int  TC  = 40;
  localparam time PER = 10;

  logic clk_50M = 1'b0;
  logic rst     = 1'b1;
  always #5 clk_50M = ~clk_50M;

  uart_word_loader_if #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW)) bus ();

  uart_word_loader #(
    .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .MEM_LEN(ML), .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk_50M(clk_50M),
    .rst    (rst),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];

  bit          pending;
  logic [7:0]  m_lo;
  time         t_lo;
  logic [15:0] m_addr, m_count, m_data, m_csum;
  bit          m_wrapped, m_resync;

  // Record every observed write as {addr, data}
  always @(negedge clk_50M) begin
    #2;
    if (bus.word_write === 1'b1) obs_q.push_back({bus.word_addr, bus.word_data});
  end

  initial begin
    #(PER * 100000);
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pending = 0; m_lo = 0; t_lo = 0;
    m_addr = 0; m_count = 0; m_data = 0; m_csum = 0;
    m_wrapped = 0; m_resync = 0;
  endtask

  // A low byte left unpaired longer than TC cycles has been discarded by now
  task automatic settle();
    if (pending && ($time - t_lo) > TC * PER) begin
      pending  = 0;
      m_resync = 1;
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input time t, input bit suppress);
    if (bus.load_en !== 1'b1) return;
    if (pending && (t - t_lo) <= TC * PER) begin
      m_data  = {b, m_lo};
      pending = 0;
      if (!suppress) begin
        exp_q.push_back({m_addr, m_data});
        m_csum = m_csum + m_data;
        if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
        if (m_addr == 16'(ML - 1)) begin
          m_addr    = 0;
          m_wrapped = 1;
        end else begin
          m_addr = m_addr + 16'd1;
        end
      end
    end else begin
      if (pending) m_resync = 1;
      pending = 1;
      m_lo    = b;
      t_lo    = t;
    end
  endtask

  // Called at a negedge; edge spacing to the next byte is hold+gap cycles
  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    bus.byte_data  = b;
    bus.byte_ready = 1'b1;
    @(posedge clk_50M);
    model_byte(b, $time, 1'b0);
    repeat (hold - 1) @(posedge clk_50M);
    @(negedge clk_50M);
    bus.byte_ready = 1'b0;
    repeat (gap) @(negedge clk_50M);
  endtask

  task automatic send_word(input logic [15:0] w);
    send_byte(w[7:0], 1, 1);
    send_byte(w[15:8], 1, 2);
  endtask

  task automatic load_on();
    bus.load_en = 1'b1;
    m_addr = 0; m_count = 0; m_wrapped = 0; m_resync = 0; m_csum = 0;
    repeat (2) @(negedge clk_50M);
  endtask

  task automatic load_off();
    settle();
    bus.load_en = 1'b0;
    pending = 0;
    repeat (2) @(negedge clk_50M);
  endtask

  task automatic check_state(input string tag);
    int n;
    settle();
    chk({tag, "/nwrites"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "/write"}, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
    chk({tag, "/addr"},    32'(bus.word_addr),  32'(m_addr));
    chk({tag, "/count"},   32'(bus.word_count), 32'(m_count));
    chk({tag, "/data"},    32'(bus.word_data),  32'(m_data));
    chk({tag, "/wrapped"}, 32'(bus.wrapped),    32'(m_wrapped));
    chk({tag, "/resync"},  32'(bus.resync),     32'(m_resync));
    chk({tag, "/strobe"},  32'(bus.word_write), 32'd0);
`ifdef UART_LOADER_CHECKSUM_EN
    chk({tag, "/csum"},    32'(bus.checksum),   32'(m_csum));
`endif
  endtask

  initial begin
    bus.load_en    = 1'b0;
    bus.byte_data  = 8'h00;
    bus.byte_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_50M);
    check_state("reset");
    rst = 1'b0;
    @(negedge clk_50M);

    load_on();
    send_word(16'h1234);
    repeat (4) @(negedge clk_50M);
    check_state("one_word");
    load_off();

    load_on();
    send_word(16'h0001);
    send_word(16'h0002);
    send_word(16'hBEEF);
    repeat (4) @(negedge clk_50M);
    check_state("three_words");
    load_off();

    load_on();
    for (int i = 0; i < ML + 1; i++) send_word(16'(16'hA000 + i));
    repeat (4) @(negedge clk_50M);
    check_state("wrap");
    load_off();

    load_on();
    send_byte(8'hAA, 1, TC + 2);
    send_word(16'h5678);
    repeat (4) @(negedge clk_50M);
    check_state("timeout");
    send_byte(8'h01, 1, TC - 1);
    send_byte(8'h02, 1, 2);
    send_byte(8'h03, 1, TC);
    send_byte(8'h04, 1, 2);
    send_byte(8'h05, 1, 2);
    repeat (4) @(negedge clk_50M);
    check_state("timeout_edge");
    load_off();

    load_on();
    send_byte(8'h11, 1, 2);
    load_off();
    send_byte(8'h99, 1, 2);
    repeat (3) @(negedge clk_50M);
    check_state("load_off");
    load_on();
    send_word(16'h3322);
    repeat (4) @(negedge clk_50M);
    check_state("relaunch");
    load_off();

    load_on();
    send_word(16'h0102);
    send_byte(8'h5A, 1, 2);
    bus.byte_data  = 8'hC3;
    bus.byte_ready = 1'b1;
    @(posedge clk_50M);
    model_byte(8'hC3, $time, 1'b1);
    @(negedge clk_50M);
    bus.load_en    = 1'b0;
    bus.byte_ready = 1'b0;
    pending        = 0;
    repeat (3) @(negedge clk_50M);
    check_state("write_drop");
    load_on();
    check_state("session_clr");

    send_byte(8'h6D, 10, 2);
    send_byte(8'hE1, 10, 2);
    repeat (4) @(negedge clk_50M);
    check_state("held_ready");

    send_byte(8'h44, 1, 2);
    rst = 1'b1;
    @(negedge clk_50M);
    model_reset();
    exp_q.delete();
    check_state("mid_reset");
    rst = 1'b0;
    repeat (2) @(negedge clk_50M);
    load_on();
    send_word(16'h7E7E);
    repeat (4) @(negedge clk_50M);
    check_state("after_reset");
    load_off();

    for (int s = 0; s < 4; s++) begin
      load_on();
      for (int k = 0; k < 14; k++) begin
        int hold, gap;
        hold = $urandom_range(1, 3);
        gap  = ($urandom_range(0, 7) == 0) ? TC + $urandom_range(0, 3) : $urandom_range(1, 4);
        send_byte(8'($urandom), hold, gap);
      end
      repeat (TC + 5) @(negedge clk_50M);
      check_state($sformatf("random%0d", s));
      load_off();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
